// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    if (neg) begin
      return ~v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if64(input logic neg, input logic [2*XLEN-1:0] v);
    if (neg) begin
      return ~v + 64'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 one-bit iterations on operand magnitudes,
// followed by one sign-correction cycle. Fixed 33-cycle busy window.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        op_r;
  logic              neg_a_r, neg_b_r;
  logic [XLEN-1:0]   a_raw_r, a_mag_r, b_mag_r, quo_r, rem_r, result_r;
  logic [2*XLEN-1:0] prod_r;
  logic              busy_r, done_r, busy_s, done_s;

  logic              a_signed_s, b_signed_s, last_s, div_ok_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, quo_fix_s, rem_fix_s, result_s;
  logic [XLEN:0]     mul_sum_s, div_shift_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic              b_zero_s, ovf_s;

  // Operand signedness and magnitudes for the request on the inputs.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      F3_MULHSU: a_signed_s = 1'b1;
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    a_mag_s = neg_if(a_signed_s & src_a[XLEN-1], src_a);
    b_mag_s = neg_if(b_signed_s & src_b[XLEN-1], src_b);
  end

  // One shift-add step and one restoring-division step per CALC cycle.
  always_comb begin
    mul_sum_s   = {1'b0, prod_r[2*XLEN-1:XLEN]} + (prod_r[0] ? {1'b0, a_mag_r} : {(XLEN+1){1'b0}});
    div_shift_s = {rem_r, quo_r[XLEN-1]};
    div_ok_s    = (div_shift_s >= {1'b0, b_mag_r});
    last_s      = (cnt_r == {CNT_W{1'b1}});
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (start) state_s = ST_CALC; else state_s = ST_IDLE;
      ST_CALC: if (last_s) state_s = ST_FIN;  else state_s = ST_CALC;
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode, registered below so busy/done come straight from flops.
  always_comb begin
    busy_s = (state_s != ST_IDLE);
    done_s = (state_r == ST_FIN);
  end

  // Sign correction and special-case selection in FIN.
  always_comb begin
    prod_fix_s = neg_if64(neg_a_r ^ neg_b_r, prod_r);
    quo_fix_s  = neg_if(neg_a_r ^ neg_b_r, quo_r);
    rem_fix_s  = neg_if(neg_a_r, rem_r);
    b_zero_s   = (b_mag_r == 32'h0000_0000);
    ovf_s      = (a_raw_r == 32'h8000_0000) && neg_b_r && (b_mag_r == 32'h0000_0001);
    result_s   = result_r;
    case (op_r)
      F3_MUL:                       result_s = prod_fix_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_s = prod_fix_s[2*XLEN-1:XLEN];
      F3_DIV: begin
        if (b_zero_s)   result_s = 32'hFFFF_FFFF;
        else if (ovf_s) result_s = 32'h8000_0000;
        else            result_s = quo_fix_s;
      end
      F3_DIVU: if (b_zero_s) result_s = 32'hFFFF_FFFF; else result_s = quo_r;
      F3_REM: begin
        if (b_zero_s)   result_s = a_raw_r;
        else if (ovf_s) result_s = 32'h0000_0000;
        else            result_s = rem_fix_s;
      end
      F3_REMU: if (b_zero_s) result_s = a_raw_r; else result_s = rem_r;
      default: result_s = result_r;
    endcase
  end

  // Datapath registers: latch on accept, iterate in CALC, write result in FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= 5'd0;
      op_r     <= 3'b000;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      a_raw_r  <= 32'h0;
      a_mag_r  <= 32'h0;
      b_mag_r  <= 32'h0;
      quo_r    <= 32'h0;
      rem_r    <= 32'h0;
      prod_r   <= 64'h0;
      result_r <= 32'h0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            cnt_r   <= 5'd0;
            op_r    <= funct3;
            neg_a_r <= a_signed_s & src_a[XLEN-1];
            neg_b_r <= b_signed_s & src_b[XLEN-1];
            a_raw_r <= src_a;
            a_mag_r <= a_mag_s;
            b_mag_r <= b_mag_s;
            quo_r   <= a_mag_s;
            rem_r   <= 32'h0;
            prod_r  <= {32'h0, b_mag_s};
          end
        end
        ST_CALC: begin
          cnt_r  <= cnt_r + 5'd1;
          prod_r <= {mul_sum_s, prod_r[XLEN-1:1]};
          quo_r  <= {quo_r[XLEN-2:0], div_ok_s};
          rem_r  <= div_ok_s ? (div_shift_s[XLEN-1:0] - b_mag_r) : div_shift_s[XLEN-1:0];
        end
        ST_FIN:  result_r <= result_s;
        default: result_r <= result_r;
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops against
// an arithmetic reference model, and handshake/reset sequences.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Reference model straight from the RV32M arithmetic rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'b101: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Counts edges from the current sample point until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Issue one op, scramble inputs after accept, check latency, busy, done and result.
  // Returns sampled in the done cycle.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int n;
    @(negedge clk);
    start = 1'b1; funct3 = f3; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    funct3 = 3'($urandom_range(7, 0));
    src_a = $urandom();
    src_b = $urandom();
    check({name, "_busy"}, {31'h0, busy}, 32'd1);
    wait_done(n);
    check({name, "_lat"}, n, 32'd33);
    check({name, "_done"}, {31'h0, done}, 32'd1);
    check({name, "_busy_off"}, {31'h0, busy}, 32'd0);
    check({name, "_res"}, result, exp);
  endtask

  task automatic step_hold(input string name, input logic [31:0] exp);
    @(posedge clk); #1;
    check({name, "_pulse"}, {31'h0, done}, 32'd0);
    check({name, "_hold"}, result, exp);
  endtask

  initial begin
    int n, dones;
    logic [2:0]  f3;
    logic [31:0] a, b, e;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,          32'd14};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,          32'd2};
    vecs[8]  = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[9]  = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1};
    vecs[10] = '{3'b100, 32'd5,         32'd0,          32'hFFFF_FFFF};
    vecs[11] = '{3'b101, 32'd5,         32'd0,          32'hFFFF_FFFF};
    vecs[12] = '{3'b110, 32'd5,         32'd0,          32'd5};
    vecs[13] = '{3'b111, 32'hFFFF_FFF0, 32'd0,          32'hFFFF_FFF0};
    vecs[14] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[15] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

    rst = 1'b1; start = 1'b0; funct3 = 3'b000; src_a = 32'h0; src_b = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_res", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
      step_hold($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom_range(7, 0));
      a = pick();
      b = pick();
      e = ref_model(f3, a, b);
      do_op($sformatf("rnd%0d_f%0d_%08h_%08h", i, f3, a, b), f3, a, b, e);
      step_hold($sformatf("rnd%0d", i), e);
    end

    // start held high through busy with operands changing: exactly one done
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    dones = 0; n = 0;
    while (done !== 1'b1 && n < 100) begin
      src_a = $urandom(); src_b = $urandom(); funct3 = 3'($urandom_range(7, 0));
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("hold_lat", n, 32'd33);
    check("hold_res", result, 32'd14);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("hold_extra_done", dones, 32'd0);
    check("hold_idle", {31'h0, busy}, 32'd0);

    // Back-to-back: start in the done cycle is accepted with no gap
    do_op("b2b_first", 3'b000, 32'd12, 32'd11, 32'd132);
    start = 1'b1; funct3 = 3'b101; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; src_a = 32'h0; src_b = 32'h0;
    check("b2b_busy", {31'h0, busy}, 32'd1);
    wait_done(n);
    check("b2b_lat", n, 32'd33);
    check("b2b_res", result, 32'd333);

    // Asynchronous reset 10 cycles into CALC abandons the op
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    check("prerst_busy", {31'h0, busy}, 32'd1);
    check("prerst_res", result, 32'd333);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'h0, busy}, 32'd0);
    check("arst_done", {31'h0, done}, 32'd0);
    check("arst_res", result, 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("arst_no_done", dones, 32'd0);
    check("arst_res_zero", result, 32'd0);

    do_op("post_rst", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    step_hold("post_rst", 32'hFFFF_FFF2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
